// File: rtl/gui_frame_sequencer.sv
// Video raster timing generator with a frame-synchronous overlay config update.
// Config words are captured on request and only take effect at the vblank boundary.
module gui_frame_sequencer #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        upd_req,
  input  logic [15:0] upd_data,
  output logic        upd_ack,
  output logic [10:0] h_count,
  output logic [9:0]  v_count,
  output logic        active_draw,
  output logic        h_sync,
  output logic        v_sync,
  output logic        new_frame,
  output logic [5:0]  frame_count,
  output logic [15:0] cfg_active
);

  localparam int TOTAL_PIXELS = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int TOTAL_LINES  = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [10:0] H_ACT   = 11'(ACTIVE_H_PIXELS);
  localparam logic [10:0] H_LAST  = 11'(TOTAL_PIXELS - 1);
  localparam logic [10:0] HS_BEG  = 11'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [10:0] HS_END  = 11'(TOTAL_PIXELS - H_BACK_PORCH);
  localparam logic [9:0]  V_ACT   = 10'(ACTIVE_LINES);
  localparam logic [9:0]  V_LAST  = 10'(TOTAL_LINES - 1);
  localparam logic [9:0]  VS_BEG  = 10'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [9:0]  VS_END  = 10'(TOTAL_LINES - V_BACK_PORCH);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_e;

  state_e      state_q, state_d;
  logic [10:0] h_q, h_d, h_nxt;
  logic [9:0]  v_q, v_d, v_nxt;
  logic        act_q, act_d, hs_q, hs_d, vs_q, vs_d, nf_q, nf_d, ack_q, ack_d;
  logic [5:0]  fc_q, fc_d;
  logic [15:0] cfg_q, cfg_d, pend_q, pend_d;

  always_comb begin
    h_nxt   = (h_q == H_LAST) ? 11'd0 : h_q + 11'd1;
    v_nxt   = v_q;
    if (h_q == H_LAST) v_nxt = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;

    h_d     = h_q;
    v_d     = v_q;
    act_d   = act_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    nf_d    = 1'b0;
    ack_d   = 1'b0;
    fc_d    = fc_q;
    cfg_d   = cfg_q;
    pend_d  = pend_q;
    state_d = state_q;

    if (enable) begin
      // Flags are computed from the next count so they line up with it.
      h_d   = h_nxt;
      v_d   = v_nxt;
      act_d = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      hs_d  = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
      vs_d  = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
      nf_d  = (h_nxt == H_ACT) && (v_nxt == V_ACT);
      if (nf_q) fc_d = fc_q + 6'd1;

      unique case (state_q)
        IDLE: begin
          // The requester still holds upd_req during the ack cycle; don't re-capture it.
          if (upd_req && !ack_q) begin
            pend_d  = upd_data;
            state_d = PENDING;
          end
        end
        PENDING: begin
          if (nf_q) begin
            cfg_d   = pend_q;
            state_d = APPLY;
          end
        end
        APPLY: begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      act_q   <= 1'b1;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      nf_q    <= 1'b0;
      ack_q   <= 1'b0;
      fc_q    <= '0;
      cfg_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      act_q   <= act_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      nf_q    <= nf_d;
      ack_q   <= ack_d;
      fc_q    <= fc_d;
      cfg_q   <= cfg_d;
      pend_q  <= pend_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign active_draw = act_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign new_frame   = nf_q;
  assign upd_ack     = ack_q;
  assign frame_count = fc_q;
  assign cfg_active  = cfg_q;

endmodule

// File: tb/tb_gui_frame_sequencer.sv
// Bench for gui_frame_sequencer using a reduced raster so many frames fit in a short run.
module tb_gui_frame_sequencer;
  localparam int AH = 16, HFP = 2, HSW = 3, HBP = 4;
  localparam int AL = 8, VFP = 1, VSW = 2, VBP = 3;
  localparam int TP = AH + HFP + HSW + HBP;
  localparam int TL = AL + VFP + VSW + VBP;
  localparam int FRAME = TP * TL;

  logic        clk = 0, rst = 0, enable = 0, upd_req = 0;
  logic [15:0] upd_data = '0;
  logic        upd_ack, active_draw, h_sync, v_sync, new_frame;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic [5:0]  frame_count;
  logic [15:0] cfg_active;

  gui_frame_sequencer #(
    .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
    .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .upd_req(upd_req), .upd_data(upd_data),
    .upd_ack(upd_ack), .h_count(h_count), .v_count(v_count), .active_draw(active_draw),
    .h_sync(h_sync), .v_sync(v_sync), .new_frame(new_frame), .frame_count(frame_count),
    .cfg_active(cfg_active)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Reference raster model, advanced on enabled edges.
  int mh, mv, mfc, en_cnt;
  bit men;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mh <= 0; mv <= 0; mfc <= 0; men <= 0; en_cnt <= 0;
    end else begin
      men <= enable;
      if (enable) begin
        en_cnt <= en_cnt + 1;
        if (mh == TP - 1) begin
          mh <= 0;
          mv <= (mv == TL - 1) ? 0 : mv + 1;
        end else mh <= mh + 1;
        if (men && mh == AH && mv == AL) mfc <= (mfc + 1) % 64;
      end
    end
  end

  logic [15:0] sb_q[$];
  int acks = 0, since_cfg = 100, last_nf_cnt = 0;
  bit seen_nf = 0, prev_nf = 0, prev_rst = 0;
  logic [15:0] prev_cfg = '0;
  logic [3:0] exp_flags;

  always @(negedge clk) begin
    exp_flags = {mh < AH && mv < AL, mh >= AH + HFP && mh < TP - HBP,
                 mv >= AL + VFP && mv < TL - VBP, men && mh == AH && mv == AL};
    chk("h_count", 32'(h_count), 32'(mh));
    chk("v_count", 32'(v_count), 32'(mv));
    chk("flags", 32'({active_draw, h_sync, v_sync, new_frame}), 32'(exp_flags));
    chk("frame_count", 32'(frame_count), 32'(mfc));
    if (!rst) begin
      chk("rst_cfg", 32'(cfg_active), 32'h0);
      chk("rst_ack", 32'(upd_ack), 32'h0);
      sb_q.delete();
      seen_nf = 0;
    end else begin
      if (prev_rst && cfg_active !== prev_cfg) begin
        chk("cfg_after_nf", 32'(prev_nf), 32'h1);
        since_cfg = 0;
      end else since_cfg++;
      if (upd_ack) begin
        acks++;
        chk("ack_lag", 32'(since_cfg), 32'h1);
        if (sb_q.size() == 0) chk("ack_expected", 32'h0, 32'h1);
        else chk("cfg_on_ack", 32'(cfg_active), 32'(sb_q.pop_front()));
      end
      if (new_frame) begin
        if (seen_nf) chk("nf_period", 32'(en_cnt - last_nf_cnt), 32'(FRAME));
        seen_nf = 1;
        last_nf_cnt = en_cnt;
      end
    end
    prev_cfg = cfg_active;
    prev_nf  = new_frame;
    prev_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_hv(input int h, input int v);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (h_count == 11'(h) && v_count == 10'(v)) return;
    end
    chk("wait_hv_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (upd_ack) begin
        upd_req = 0;
        return;
      end
    end
    upd_req = 0;
    chk("wait_ack_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int a0, f0;
    bit got;
    repeat (3) tick();
    chk("rst_h", 32'(h_count), 32'h0);
    chk("rst_active", 32'(active_draw), 32'h1);
    rst = 1; enable = 1;

    // Free-running frames; line wrap checked explicitly too.
    repeat (2 * FRAME + 10) tick();
    wait_hv(TP - 1, 2);
    tick();
    chk("h_wrap", 32'({21'(0), h_count}), 32'h0);
    chk("v_inc", 32'(v_count), 32'h3);

    // Mid-frame update.
    wait_hv(3, 2);
    a0 = acks;
    upd_data = 16'hBEEF; upd_req = 1; sb_q.push_back(16'hBEEF);
    wait_ack();
    repeat (4) tick();
    chk("beef_acks", 32'(acks - a0), 32'h1);
    chk("beef_cfg", 32'(cfg_active), 32'hBEEF);

    // Request on the new_frame cycle applies at the following frame.
    wait_hv(AH, AL);
    f0 = int'(frame_count);
    upd_data = 16'h1234; upd_req = 1; sb_q.push_back(16'h1234);
    wait_ack();
    chk("1234_frame", 32'(frame_count), 32'((f0 + 2) % 64));

    // Freeze just before new_frame.
    wait_hv(AH - 1, AL);
    enable = 0;
    repeat (100) tick();
    chk("frz_h", 32'(h_count), 32'(AH - 1));
    chk("frz_v", 32'(v_count), 32'(AL));
    enable = 1;
    tick();
    chk("nf_after_en", 32'(new_frame), 32'h1);

    // Frame counter wrap.
    got = 0;
    for (int i = 0; i < 70 * FRAME && !got; i++) begin
      tick();
      if (frame_count == 6'd63) got = 1;
    end
    chk("fc_reach63", 32'(got), 32'h1);
    got = 0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      tick();
      if (frame_count != 6'd63) got = 1;
    end
    chk("fc_wrap", 32'(frame_count), 32'h0);

    // Reset while PENDING.
    a0 = acks;
    wait_hv(2, 1);
    upd_data = 16'hCAFE; upd_req = 1; sb_q.push_back(16'hCAFE);
    repeat (3) tick();
    upd_req = 0;
    rst = 0;
    repeat (3) tick();
    chk("rstp_cfg", 32'(cfg_active), 32'h0);
    rst = 1;
    repeat (2 * FRAME) tick();
    chk("rstp_no_ack", 32'(acks - a0), 32'h0);
    chk("rstp_cfg_after", 32'(cfg_active), 32'h0);

    // Data changes while PENDING are ignored.
    wait_hv(3, 1);
    upd_data = 16'hAAAA; upd_req = 1; sb_q.push_back(16'hAAAA);
    repeat (3) tick();
    upd_data = 16'h5555;
    wait_ack();
    tick();
    chk("aaaa_cfg", 32'(cfg_active), 32'hAAAA);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
